mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
//
// PURPOSE
//  Multi-cycle multiply/divide unit owning the architectural HI/LO registers. It replaces the single-cycle
//  64-bit product/quotient path of the combinational ALU with iterative radix-2 engines (one bit per clock),
//  generalised to WIDTH. The core issues an op with start, stalls MFHI/MFLO and any new MDU op while busy,
//  and reads hi/lo directly.
//
// PARAMETERS
//  WIDTH     32   operand width; hi and lo are each WIDTH bits; must be >= 4 and even
//
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high reset
//  start       in   1      op request; accepted on an edge where start=1 and busy=0
//  op          in   3      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op (accepted, no effect, done pulses)
//  operand_a   in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO source
//  operand_b   in   WIDTH  rt: multiplier / divisor
//  busy        out  1      1 while an iterative op is in flight
//  done        out  1      one-cycle pulse: op result committed to hi/lo on the edge that raised it
//  hi          out  WIDTH  HI register (product upper half / remainder)
//  lo          out  WIDTH  LO register (product lower half / quotient)
//  div_zero    out  1      only with MDU_DIV_ZERO_EN: pulses with done when a DIV/DIVU had operand_b=0
//
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, done=0, div_zero=0, FSM->IDLE. Reset mid-op aborts it; no writeback, no done.
//  - FSM IDLE -> RUN -> FIX -> IDLE. Accept edge E0 (MULT/MULTU/DIV/DIVU): latch operands, take magnitudes
//    (signed ops only), clear counter, go RUN, busy=1.
//  - RUN: edges E1..E_WIDTH, one iteration each (shift-add multiply; restoring divide); counter 0..WIDTH-1.
//  - FIX: edge E_(WIDTH+1): apply sign correction, write hi/lo, busy->0, done=1 for one cycle, go IDLE.
//    Busy spans exactly WIDTH+1 cycles (33 at WIDTH=32). A new start is accepted on the edge after done.
//  - start while busy=1 is ignored (not queued); operands/op may change freely during busy.
//  - MTHI/MTLO/no-op: complete on E0 (MTHI: hi<=operand_a; MTLO: lo<=operand_a); busy stays 0; done=1 the
//    following cycle. Back-to-back MTHI then MTLO on consecutive edges both take effect.
//  - MULT: {hi,lo} = signed a * signed b, full 2*WIDTH product. MULTU: unsigned.
//  - DIV: quotient truncates toward zero -> lo; remainder takes dividend sign -> hi.
//    Overflow (a = min negative, b = -1): lo = min negative (0x80000000), hi = 0. DIVU: unsigned.
//  - Divide by zero (default build): runs full latency; DIVU gives lo=all ones, hi=a;
//    DIV gives hi=a, lo = (a<0) ? 1 : all ones.
//  - hi/lo change only at commit edges, MTHI/MTLO edges, or reset; stable and valid whenever busy=0.
//
// CONFIGURATION
//  MDU_DIV_ZERO_EN defined: DIV/DIVU with operand_b=0 detected at E0; no iteration, busy stays 0, hi/lo
//    unchanged, done and div_zero pulse together the next cycle. Port div_zero present.
//  Not defined: no detection; divide by zero follows the default-build values above; port div_zero absent.
//
// TESTING
//  1 MULT a=0xFFFFFFFE(-2) b=7 -> done 33 cycles after start edge, hi=0xFFFFFFFF lo=0xFFFFFFF2; busy high 33 cycles
//  2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//  4 DIVU a=100 b=0 -> default: lo=0xFFFFFFFF hi=100 after 33 cycles; MDU_DIV_ZERO_EN: hi/lo unchanged,
//    done+div_zero next cycle
//  5 MTHI 0x1234 then MTLO 0x5678 on consecutive edges -> hi=0x1234 lo=0x5678, busy never 1; start during busy ignored
//  6 reset at cycle 10 of a DIVU -> hi=lo=0, busy=0, no done pulse; next MULTU 3*5 -> lo=15 hi=0

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit owning HI/LO
//
// Purpose:
//   Multi-cycle MULT/MULTU/DIV/DIVU engine (one bit per clock) plus MTHI/MTLO
//   moves. Results land in the architectural hi/lo registers on the commit
//   edge; the core stalls on busy.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   op request, accepted when busy=0
//   op         in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   operand_a  in   rs operand
//   operand_b  in   rt operand
//   busy       out  iterative op in flight
//   done       out  one-cycle pulse after hi/lo commit
//   hi, lo     out  architectural HI/LO registers
//   div_zero   out  only when MDU_DIV_ZERO_EN is defined: divide-by-zero pulse
//
// Configuration:
//   MDU_DIV_ZERO_EN  short-circuit DIV/DIVU by zero at accept and flag it.

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV_ZERO_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend->quotient
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;        // negate product or quotient
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod;

    // MULT and DIV have op[0]=0; magnitudes are taken only for those.
    assign signed_op = ~op[0];
    assign abs_a = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign abs_b = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, acc_hi, acc_lo} right by one.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // Restoring divide step: bring the next dividend bit into the remainder.
    assign div_rs   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff = div_rs - {1'b0, mcand_q};
    assign div_ge   = (div_rs >= {1'b0, mcand_q});

    assign prod = {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            mcand_d   = abs_a;
                            acc_hi_d  = '0;
                            acc_lo_d  = abs_b;
                            is_div_d  = 1'b0;
                            neg_d     = signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                            rem_neg_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                        end
                        3'd2, 3'd3: begin
`ifdef MDU_DIV_ZERO_EN
                            if (operand_b == '0) begin
                                done_d     = 1'b1;
                                div_zero_d = 1'b1;
                            end else begin
`else
                            begin
`endif
                                mcand_d   = abs_b;
                                acc_hi_d  = '0;
                                acc_lo_d  = abs_a;
                                is_div_d  = 1'b1;
                                neg_d     = signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                                rem_neg_d = signed_op & operand_a[WIDTH-1];
                                cnt_d     = '0;
                                state_d   = ST_RUN;
                            end
                        end
                        3'd4: begin
                            hi_d   = operand_a;
                            done_d = 1'b1;
                        end
                        3'd5: begin
                            lo_d   = operand_a;
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // A zero divisor yields quotient all ones and remainder |a|
                // naturally; the sign fix then gives the required DIV values.
                if (is_div_q) begin
                    lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? -prod : prod;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifdef MDU_DIV_ZERO_EN
    assign div_zero = div_zero_q;
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
`ifdef MDU_DIV_ZERO_EN
    logic          div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
`ifdef MDU_DIV_ZERO_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_dz(input logic [2:0] o, input logic [W-1:0] b);
        return (o == 3'd2 || o == 3'd3) && b == '0;
    endfunction

    // Architectural reference: plain 64-bit arithmetic on the operands.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd2: begin
                if (b == 0) begin
`ifndef MDU_DIV_ZERO_EN
                    m_hi = a;
                    m_lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
`endif
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[W-1:0];
                    m_hi = r[W-1:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
`ifndef MDU_DIV_ZERO_EN
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
`endif
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op (inputs driven #1 after a rising edge), then wait for done.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, bcnt, exp_lat;
        logic iter;
        iter = (o <= 3'd3);
`ifdef MDU_DIV_ZERO_EN
        if (is_dz(o, b)) iter = 1'b0;
`endif
        exp_lat = iter ? W + 1 : 0;
        check("idle_before_start", {63'd0, busy}, 64'd0);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        model(o, a, b);
        n = 0; bcnt = 0;
        if (iter) check("done_pulse_width", {63'd0, done}, 64'd0);
        while (!done && n < 100) begin
            if (busy) bcnt++;
            if (n == 5) begin
                // Start while busy must be ignored even with new op/operands.
                start = 1'b1; op = 3'd4; operand_a = $urandom; operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
        check($sformatf("latency op%0d", o), 64'(n), 64'(exp_lat));
        check($sformatf("busy_cycles op%0d", o), 64'(bcnt), 64'(exp_lat));
        check($sformatf("busy_at_done op%0d", o), {63'd0, busy}, 64'd0);
        check($sformatf("result op%0d a=%0h b=%0h", o, a, b), {hi, lo}, {m_hi, m_lo});
`ifdef MDU_DIV_ZERO_EN
        check($sformatf("div_zero op%0d", o), {63'd0, div_zero}, {63'd0, is_dz(o, b)});
`endif
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0] o;
        reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd7);
        check("mult_-2x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd2, -32'd7, 32'd2);
        check("div_-7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd3, 32'd100, 32'd0);
`ifndef MDU_DIV_ZERO_EN
        check("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
`endif
        do_op(3'd2, -32'd9, 32'd0);
        do_op(3'd4, 32'h1234, 32'd0);
        do_op(3'd5, 32'h5678, 32'd0);
        check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);
        do_op(3'd6, 32'hDEAD, 32'hBEEF);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            do_op(o, pick(), pick());
        end

        // Reset ten cycles into a DIVU: abort with no writeback and no done.
        start = 1'b1; op = 3'd3; operand_a = 32'd12345; operand_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);
        do_op(3'd1, 32'd3, 32'd5);
        check("multu_3x5", {hi, lo}, 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
